// File: rtl/divisor_secuencial.sv
// Iterative unsigned restoring divider: one quotient bit per clock through a
// single shared (N+1)-bit subtractor, under a start/busy/done handshake.
module divisor_secuencial #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIN
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [N:0]      r_rem;
  logic [N-1:0]    r_quo;
  logic [N:0]      r_dvs;
  logic [CW-1:0]   r_cnt;

  logic            w_accept;
  logic            w_dvs_zero;
  logic            w_last;
  logic [N+1:0]    w_diff;
  logic            w_borrow;
  logic [N:0]      w_rem_nx;
  logic [N-1:0]    w_quo_nx;

  assign w_accept   = start && (r_state != ITER);
  assign w_dvs_zero = (divisor == '0);
  assign w_last     = (r_cnt == '0);

  // R[N] is always 0 between iterations, so {R, Q[N-1]} equals the zero-extended
  // shifted value T; the top bit of the difference is then the borrow.
  assign w_diff   = {r_rem, r_quo[N-1]} - {1'b0, r_dvs};
  assign w_borrow = w_diff[N+1];
  assign w_rem_nx = w_borrow ? {r_rem[N-1:0], r_quo[N-1]} : w_diff[N:0];
  assign w_quo_nx = {r_quo[N-2:0], ~w_borrow};

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE, FIN: begin
        done = (r_state == FIN);
        if (w_accept) w_next = w_dvs_zero ? FIN : ITER;
        else          w_next = IDLE;
      end
      ITER: begin
        busy = 1'b1;
        if (w_last) w_next = FIN;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      if (w_dvs_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        r_rem <= '0;
        r_quo <= dividend;
        r_dvs <= {1'b0, divisor};
        r_cnt <= CW'(N - 1);
      end
    end else if (r_state == ITER) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt - 1'b1;
      if (w_last) begin
        quotient    <= w_quo_nx;
        remainder   <= w_rem_nx[N-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed bench for divisor_secuencial: latency, results, div-by-zero,
// ignored start while busy, back-to-back issue and mid-operation reset.
module tb_divisor_secuencial;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divisor_secuencial #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (done !== 1'b1 && lat <= 200) begin
      if (busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b q=%h r=%h expected all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_vector(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz,
                             input int elat, input int ebusy);
    int lat, bcnt;
    start_op(a, b);
    wait_done(lat, bcnt);
    checks++;
    if (lat !== elat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
    end
    checks++;
    if (bcnt !== ebusy) begin
      errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, bcnt, ebusy);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
    end
    checks++;
    if (quotient !== eq) begin
      errors++; $display("FAIL %s quotient: got %h expected %h", name, quotient, eq);
    end
    checks++;
    if (remainder !== er) begin
      errors++; $display("FAIL %s remainder: got %h expected %h", name, remainder, er);
    end
    checks++;
    if (div_by_zero !== edz) begin
      errors++; $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, edz);
    end
    tick();
    checks++;
    if (done !== 1'b0 || quotient !== eq || remainder !== er) begin
      errors++;
      $display("FAIL %s after_done: got done=%b q=%h r=%h expected done=0 q=%h r=%h",
               name, done, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    start_op(32'd50, 32'd6);
    repeat (9) tick();
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_ignore_start: got busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    wait_done(lat, bcnt);
    checks++;
    if (lat + 10 !== 33) begin
      errors++; $display("FAIL b2b_first_done_cycle: got %0d expected 33", lat + 10);
    end
    checks++;
    if (quotient !== 32'd8 || remainder !== 32'd2) begin
      errors++; $display("FAIL b2b_first_result: got q=%0d r=%0d expected q=8 r=2", quotient, remainder);
    end
    start_op(32'd9, 32'd3);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_no_bubble: got busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    wait_done(lat, bcnt);
    checks++;
    if (33 + lat !== 66) begin
      errors++; $display("FAIL b2b_second_done_cycle: got %0d expected 66", 33 + lat);
    end
    checks++;
    if (quotient !== 32'd3 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_result: got q=%0d r=%0d dz=%b expected q=3 r=0 dz=0",
               quotient, remainder, div_by_zero);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int seen;
    start_op(32'd1000, 32'd3);
    repeat (14) tick();
    // start with a zero divisor on the reset edge must be dropped
    reset = 1'b1; start = 1'b1; dividend = 32'd5; divisor = 32'd0;
    tick();
    reset = 1'b0; start = 1'b0;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: got busy=%b done=%b dz=%b q=%h r=%h expected all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_no_done: got %0d active cycles expected 0", seen);
    end
    test_vector("after_reset_1000_3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33, 32);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_vector("100_7",   32'd100,      32'd7,        32'd14,       32'd2,      1'b0, 33, 32);
    test_vector("div0",    32'h1234,     32'd0,        32'hFFFFFFFF, 32'h1234,   1'b1, 1,  0);
    test_vector("3_5",     32'd3,        32'd5,        32'd0,        32'd3,      1'b0, 33, 32);
    test_vector("max_1",   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,      1'b0, 33, 32);
    test_vector("max_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,      1'b0, 33, 32);
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divisor_secuencial.md
# divisor_secuencial

Iterative unsigned restoring divider controller. It sequences a single (N+1)-bit subtractor, one quotient bit per clock, and shares that subtractor across all N iterations. It sits beside the ALU as the multi-cycle DIV/MOD unit. It accepts one operation at a time under a start/busy/done handshake.

## Interface
- N, 32, operand, quotient and remainder width (N ≥ 2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; sampled on rising clk edge
- start  input  1  request pulse; operands sampled on the same edge
- dividend  input  N  unsigned dividend
- divisor  input  N  unsigned divisor
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse; results valid
- quotient  output  N  unsigned quotient, held until next accepted start
- remainder  output  N  unsigned remainder, held until next accepted start
- div_by_zero  output  1  set with done when divisor was 0; held with results

## Operation
- Clocking: one clock; reset is synchronous and active-high.
- States: IDLE, ITER, FIN.
- Reset (any state, including mid-ITER):
  - state to IDLE
  - busy, done, div_by_zero, quotient, remainder, iteration counter all 0
  - in-flight operation discarded
- Start acceptance: accepted only in IDLE or FIN. In ITER, start is ignored and operands are not sampled.
- Accept, divisor ≠ 0:
  - R (N+1 bits) ← 0, Q ← dividend, D ← {1'b0, divisor}, cnt ← N-1
  - state → ITER, busy ← 1
- Accept, divisor = 0:
  - state → FIN, quotient ← all ones, remainder ← dividend, div_by_zero ← 1, done ← 1
  - busy stays 0
- Each ITER cycle:
  - T = {R[N-1:0], Q[N-1]}, shifted left with the dividend MSB injected
  - Subtractor computes T − D; borrow is T < D, i.e. the subtractor negativo flag.
  - No borrow: R ← T − D, Q ← {Q[N-2:0], 1}.
  - Borrow: R ← T (restore), Q ← {Q[N-2:0], 0}.
  - cnt decrements. When cnt = 0, the cycle transitions to FIN.
- ITER → FIN edge:
  - quotient ← final Q, remainder ← final R[N-1:0]
  - div_by_zero ← 0, done ← 1, busy ← 0
- FIN:
  - done lasts exactly one cycle; next state is IDLE unless start is accepted.
  - A start in FIN is accepted with no bubble.
- Arithmetic rules:
  - All operands are unsigned, and R never exceeds D−1 after any iteration.
  - The extra R bit exists only to absorb the shift. R[N] is always 0 at FIN.
  - No overflow is possible for divisor ≠ 0.
- Outputs quotient, remainder and div_by_zero change only on the FIN-entry edge or on reset.

## Timing
- Start edge = cycle 0.
- Normal latency:
  - ITER occupies cycles 1..N.
  - done is high during cycle N+1, i.e. after N+1 rising edges counting the start edge.
  - busy is high cycles 1..N.
- Divide-by-zero latency: done is high during cycle 1, and busy never asserts.
- Throughput:
  - One operation per N+1 cycles when start is reissued during the done cycle.
  - The new operation's busy rises the cycle after done.
- start and reset on the same edge: reset wins, and start is dropped.
- Operands need to be stable only at the accepting edge; later changes have no effect.

## Test plan
- Operation 100 / 7, N=32: done at cycle 33, quotient=14, remainder=2, div_by_zero=0; busy high cycles 1..32.
- Operation 3 / 5: quotient=0, remainder=3.
- Operation 0xFFFFFFFF / 1: quotient=0xFFFFFFFF, remainder=0.
- Operation 0xFFFFFFFF / 0xFFFFFFFF: quotient=1, remainder=0.
- Divisor 0, dividend 0x1234: done at cycle 1, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1, busy never high.
- Start 50/6, then pulse start with 9/3 at cycle 10:
  - The second start is ignored, and done occurs once at cycle 33 with q=8, r=2.
  - Issue 9/3 during the done cycle; the next done is at cycle 66 with q=3, r=0.
- Reset at cycle 15 of 1000/3:
  - Next cycle: IDLE, all outputs 0, no done pulse.
  - A subsequent 1000/3 yields q=333, r=1.
